// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS: steps the tuning word m through a programmed ramp.
// Optional SWEEP_TRIANGLE_EN adds a descending leg that returns the word to start_word.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_W = 24,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               keep_en,
  input  logic [31:0]        start_word,
  input  logic [31:0]        step_word,
  input  logic [COUNT_W-1:0] n_steps,
  input  logic [DWELL_W-1:0] dwell,
  output logic [31:0]        m,
  output logic               set,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StDwell, StStep, StFinish} state_e;

  state_e             state_q, state_d;
  logic [31:0]        m_q, m_d, step_q, step_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [DWELL_W-1:0] dlen_q, dlen_d, cnt_q, cnt_d;
  logic               set_q, set_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic               dwell_end;
`ifdef SWEEP_TRIANGLE_EN
  logic               down_q, down_d;
  logic [COUNT_W-1:0] nsteps_q, nsteps_d;
`endif

  // cnt_q is 1 in the cycle a word is loaded, so the dwell ends when it reaches dlen_q.
  assign dwell_end = (cnt_q >= dlen_q);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    step_d  = step_q;
    rem_d   = rem_q;
    dlen_d  = dlen_q;
    cnt_d   = cnt_q;
    set_d   = 1'b0;
    done_d  = 1'b0;
    en_d    = en_q;
    busy_d  = busy_q;
`ifdef SWEEP_TRIANGLE_EN
    down_d   = down_q;
    nsteps_d = nsteps_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDwell;
          m_d     = start_word;
          step_d  = step_word;
          rem_d   = n_steps;
          dlen_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
          cnt_d   = DWELL_W'(1);
          set_d   = 1'b1;
          en_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef SWEEP_TRIANGLE_EN
          down_d   = 1'b0;
          nsteps_d = n_steps;
`endif
        end
      end
      StDwell, StStep: begin
        if (!dwell_end) begin
          state_d = StDwell;
          cnt_d   = cnt_q + 1'b1;
        end else if (rem_q != '0) begin
          state_d = StStep;
          cnt_d   = DWELL_W'(1);
          set_d   = 1'b1;
          rem_d   = rem_q - 1'b1;
`ifdef SWEEP_TRIANGLE_EN
          m_d     = down_q ? (m_q - step_q) : (m_q + step_q);
`else
          m_d     = m_q + step_q;
`endif
`ifdef SWEEP_TRIANGLE_EN
        end else if (!down_q && (nsteps_q != '0)) begin
          // Turn-around: the first descending step is taken right away.
          state_d = StStep;
          cnt_d   = DWELL_W'(1);
          set_d   = 1'b1;
          down_d  = 1'b1;
          rem_d   = nsteps_q - 1'b1;
          m_d     = m_q - step_q;
`endif
        end else begin
          state_d = StFinish;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StFinish: begin
        state_d = StIdle;
        en_d    = keep_en;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      m_d     = m_q;
      cnt_d   = '0;
      set_d   = 1'b0;
      done_d  = 1'b0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      dlen_q  <= '0;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      dlen_q  <= dlen_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SWEEP_TRIANGLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_q   <= 1'b0;
      nsteps_q <= '0;
    end else begin
      down_q   <= down_d;
      nsteps_q <= nsteps_d;
    end
  end
`endif

  assign m    = m_q;
  assign set  = set_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl; outputs sampled 1 ns after each rising edge.
// Observed vector layout: {set, done, busy, en, m}.
module tb_dds_sweep_ctrl;

  logic        clk, rst, start, abort, keep_en;
  logic [31:0] start_word, step_word;
  logic [15:0] n_steps;
  logic [23:0] dwell;
  logic [31:0] m;
  logic        set, en, busy, done;
  int          checks, errors;

  dds_sweep_ctrl #(.DWELL_W(24), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .keep_en(keep_en),
    .start_word(start_word), .step_word(step_word), .n_steps(n_steps), .dwell(dwell),
    .m(m), .set(set), .en(en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [31:0] sw, input logic [31:0] st, input logic [15:0] ns,
                        input logic [23:0] dw, input logic ke);
    start_word = sw;
    step_word  = st;
    n_steps    = ns;
    dwell      = dw;
    keep_en    = ke;
    start      = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] obs;
    #3;
    obs = {set, done, busy, en, m};
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_initial got %h want %h", obs, 36'h0);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {set, done, busy, en, m};
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_held_start got %h want %h", obs, 36'h0);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs = {set, done, busy, en, m};
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_release got %h want %h", obs, 36'h0);
    end
  endtask

`ifdef SWEEP_TRIANGLE_EN
  task automatic test_triangle();
    logic [35:0] obs, exp;
    logic [31:0] em;
    launch(32'd0, 32'd10, 16'd2, 24'd1, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      case (k)
        2: em = 32'd10;
        3: em = 32'd20;
        4: em = 32'd10;
        default: em = 32'd0;
      endcase
      exp = {k <= 5, k == 6, k <= 5, 1'b1, em};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL triangle k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask
`else
  task automatic test_basic();
    logic [35:0] obs, exp;
    int idx;
    launch(32'd1000, 32'd100, 16'd3, 24'd4, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        // Scribble the configuration; the latched sweep must not notice.
        start      = 1'b0;
        start_word = 32'hDEAD_BEEF;
        step_word  = 32'd5;
        n_steps    = 16'd9;
        dwell      = 24'd1;
      end
      idx = (k - 1) / 4;
      if (idx > 3) idx = 3;
      exp = {(k == 1) || (k == 5) || (k == 9) || (k == 13), k == 17, k <= 16, k <= 17,
             32'(1000 + 100 * idx)};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [35:0] obs, exp;
    launch(32'hFFFF_FFF0, 32'h20, 16'd1, 24'd2, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      exp = {(k == 1) || (k == 3), k == 5, k <= 4, k <= 5,
             (k < 3) ? 32'hFFFF_FFF0 : 32'h0000_0010};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_dwell0();
    logic [35:0] obs, exp;
    int idx;
    launch(32'd5, 32'd1, 16'd2, 24'd0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      start = (k <= 3);
      idx = (k > 3) ? 2 : k - 1;
      exp = {k <= 3, k == 4, k <= 3, 1'b1, 32'(5 + idx)};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL dwell0 k=%0d got %h want %h", k, obs, exp);
      end
    end
  endtask
`endif

  task automatic test_abort();
    logic [35:0] obs, exp;
    launch(32'd0, 32'd7, 16'd5, 24'd3, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k <= 5) exp = {(k == 1) || (k == 4), 1'b0, 1'b1, 1'b1, (k < 4) ? 32'd0 : 32'd7};
      else        exp = {1'b0, 1'b0, 1'b0, 1'b0, 32'd7};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort k=%0d got %h want %h", k, obs, exp);
      end
      start = (k == 5);
      abort = (k == 5);
    end
  endtask

  task automatic test_abort_priority();
    logic [35:0] obs, exp;
    // Abort on the last dwell cycle, where a STEP would otherwise follow.
    launch(32'd500, 32'd1, 16'd2, 24'd2, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k <= 2) exp = {k == 1, 1'b0, 1'b1, 1'b1, 32'd500};
      else        exp = {1'b0, 1'b0, 1'b0, 1'b0, 32'd500};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_step k=%0d got %h want %h", k, obs, exp);
      end
      abort = (k == 2);
    end
    // Abort on the cycle that would enter FINISH: no done pulse.
    launch(32'd900, 32'd1, 16'd0, 24'd1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 1) exp = {1'b1, 1'b0, 1'b1, 1'b1, 32'd900};
      else        exp = {1'b0, 1'b0, 1'b0, 1'b0, 32'd900};
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_finish k=%0d got %h want %h", k, obs, exp);
      end
      abort = (k == 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] obs, exp;
    launch(32'd77, 32'd1, 16'd4, 24'd10, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 32'd77};
    obs = {set, done, busy, en, m};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_mid_pre got %h want %h", obs, exp);
    end
    #2 rst = 1'b1;
    #1;
    obs = {set, done, busy, en, m};
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_mid_async got %h want %h", obs, 36'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== 36'h0) begin
        errors++;
        $display("FAIL reset_mid_idle k=%0d got %h want %h", k, obs, 36'h0);
      end
    end
    launch(32'd42, 32'd3, 16'd1, 24'd1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      exp = {k <= 2, k == 3, k <= 2, 1'b1, (k == 1) ? 32'd42 : 32'd45};
`ifdef SWEEP_TRIANGLE_EN
      if (k == 3) exp = {1'b1, 1'b0, 1'b1, 1'b1, 32'd42};
`endif
      obs = {set, done, busy, en, m};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_restart k=%0d got %h want %h", k, obs, exp);
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    keep_en    = 1'b0;
    start_word = '0;
    step_word  = '0;
    n_steps    = '0;
    dwell      = '0;
    test_reset();
`ifdef SWEEP_TRIANGLE_EN
    test_triangle();
`else
    test_basic();
    test_wrap();
    test_dwell0();
`endif
    test_abort();
    test_abort_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
